// File: rtl/cpu_pkg.sv
// Shared CPU pipeline package: datapath widths, instruction type, bubble
// instruction, PC increment and the IF/ID payload struct.
// Reused by the IF, ID and EX stages.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   typedef logic [XLEN-1:0] addr_t;
   typedef logic [ILEN-1:0] instr_t;

   // Bubble instruction; matches a zero-initialised instruction memory.
   localparam instr_t NOP_INSTR = 32'h0000_0000;
   localparam addr_t  PC_INC    = addr_t'(4);

   // Branch targets are forced onto a word boundary.
   localparam addr_t  ALIGN_MASK = ~addr_t'(3);

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
      logic   valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage : cpu_pkg

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard controls, branch redirect, instruction memory
// port and the IF/ID register outputs.
//   master : the fetch stage (drives PC, imem address, IF/ID outputs)
//   slave  : the surroundings (hazard unit, ID stage, instruction memory)
// With IF_PERF_CNT_EN defined, stall_cnt_o / flush_cnt_o are added.
interface if_stage_if;
   import cpu_pkg::*;

   logic   start_i;
   logic   stall_i;
   logic   flush_i;
   addr_t  branch_target_i;
   addr_t  imem_addr_o;
   instr_t imem_data_i;
   addr_t  pc_o;
   addr_t  ifid_pc_o;
   instr_t ifid_instr_o;
   logic   ifid_valid_o;
   logic   halted_o;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   modport master (
      input  start_i, stall_i, flush_i, branch_target_i, imem_data_i,
      output imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o
`ifdef IF_PERF_CNT_EN
      , output stall_cnt_o, flush_cnt_o
`endif
   );

   modport slave (
      output start_i, stall_i, flush_i, branch_target_i, imem_data_i,
      input  imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o
`ifdef IF_PERF_CNT_EN
      , input stall_cnt_o, flush_cnt_o
`endif
   );

endinterface : if_stage_if

// File: rtl/pc_reg.sv
// Program counter: PC flop, next-PC selection and sticky halt flag.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   start, stall, flush  fetch enable and hazard controls
//   target               taken-branch target (low two bits dropped)
//   pc                   current PC (registered)
//   halted               PC ran past the instruction memory (registered)
//   advance_c            this cycle is a normal sequential fetch
module pc_reg
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start,
   input  logic  stall,
   input  logic  flush,
   input  addr_t target,
   output addr_t pc,
   output logic  halted,
   output logic  advance_c
);

   localparam addr_t PC_LIMIT = addr_t'(IMEM_DEPTH * 4);

   addr_t pc_next;
   logic  halted_next;

   // Priority: !start > stall > flush > halt > sequential.
   always_comb begin
      pc_next     = pc;
      halted_next = halted;
      advance_c   = 1'b0;
      if (start && !stall) begin
         if (flush) begin
            pc_next     = target & ALIGN_MASK;
            halted_next = 1'b0;
         end else if (halted || (pc >= PC_LIMIT)) begin
            halted_next = 1'b1;
         end else begin
            pc_next   = pc + PC_INC;
            advance_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         halted <= 1'b0;
      end else begin
         pc     <= pc_next;
         halted <= halted_next;
      end
   end

endmodule : pc_reg

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC (via pc_reg), drives the instruction
// memory address and holds the IF/ID pipeline register.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    if_stage_if.master: hazard controls, branch target, imem port,
//          pc_o, IF/ID outputs, halted_o
// Optional macro IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256
) (
   input  logic          clk_i,
   input  logic          rst_i,
   if_stage_if.master    bus
);

   addr_t pc;
   logic  halted;
   logic  advance;
   ifid_t ifid_q;
   ifid_t ifid_d;

   pc_reg #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_pc_reg (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .start     (bus.start_i),
      .stall     (bus.stall_i),
      .flush     (bus.flush_i),
      .target    (bus.branch_target_i),
      .pc        (pc),
      .halted    (halted),
      .advance_c (advance)
   );

   // IF/ID next value: hold on stall, capture on sequential fetch, otherwise
   // bubble (idle, flush squash, halted).
   always_comb begin
      ifid_d = ifid_q;
      if (!bus.start_i) begin
         ifid_d = IFID_BUBBLE;
      end else if (bus.stall_i) begin
         ifid_d = ifid_q;
      end else if (advance) begin
         ifid_d = '{pc: pc, instr: bus.imem_data_i, valid: 1'b1};
      end else begin
         ifid_d = IFID_BUBBLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ifid_q <= IFID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign bus.pc_o         = pc;
   assign bus.imem_addr_o  = pc;
   assign bus.halted_o     = halted;
   assign bus.ifid_pc_o    = ifid_q.pc;
   assign bus.ifid_instr_o = ifid_q.instr;
   assign bus.ifid_valid_o = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic        stall_evt;
   logic        flush_evt;

   assign stall_evt = bus.start_i & bus.stall_i;
   assign flush_evt = bus.start_i & bus.flush_i & ~bus.stall_i;

   // Saturating event counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
         if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver applies directed vectors and
// queues the hand-computed post-edge state; a monitor pops and compares
// after every rising edge.
module tb_if_stage;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] scnt_m;
   logic [31:0] fcnt_m;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ifid_pc;
      logic [31:0] ifid_instr;
      logic        valid;
      logic        halted;
      logic [31:0] scnt;
      logic [31:0] fcnt;
   } exp_t;

   exp_t exp_q[$];

   if_stage_if bus ();

   if_stage #(
      .IMEM_DEPTH (256)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   // Instruction memory model: word at byte address a holds a/4 + 100.
   assign bus.imem_data_i = (bus.imem_addr_o >> 2) + 32'd100;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pc"},        bus.pc_o,         32'h0);
      check({tag, "_imem_addr"}, bus.imem_addr_o,  32'h0);
      check({tag, "_ifid_pc"},   bus.ifid_pc_o,    32'h0);
      check({tag, "_ifid_ins"},  bus.ifid_instr_o, 32'h0);
      check({tag, "_valid"},     32'(bus.ifid_valid_o), 32'h0);
      check({tag, "_halted"},    32'(bus.halted_o),     32'h0);
`ifdef IF_PERF_CNT_EN
      check({tag, "_scnt"},      bus.stall_cnt_o,  32'h0);
      check({tag, "_fcnt"},      bus.flush_cnt_o,  32'h0);
`endif
   endtask

   // Drive one cycle of inputs and queue the expected state after the edge.
   task automatic step(input logic st, input logic stl, input logic fl, input logic [31:0] tgt,
                       input logic [31:0] epc, input logic [31:0] eipc, input logic [31:0] eins,
                       input logic ev, input logic eh);
      exp_t e;
      @(negedge clk);
      bus.start_i         = st;
      bus.stall_i         = stl;
      bus.flush_i         = fl;
      bus.branch_target_i = tgt;
      if (st && stl)        scnt_m = scnt_m + 32'd1;
      if (st && fl && !stl) fcnt_m = fcnt_m + 32'd1;
      e.pc = epc; e.ifid_pc = eipc; e.ifid_instr = eins; e.valid = ev; e.halted = eh;
      e.scnt = scnt_m; e.fcnt = fcnt_m;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   // Monitor: compare the DUT state after every rising edge against the queue.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pc",         bus.pc_o,         e.pc);
         check("imem_addr",  bus.imem_addr_o,  e.pc);
         check("ifid_pc",    bus.ifid_pc_o,    e.ifid_pc);
         check("ifid_instr", bus.ifid_instr_o, e.ifid_instr);
         check("ifid_valid", 32'(bus.ifid_valid_o), 32'(e.valid));
         check("halted",     32'(bus.halted_o),     32'(e.halted));
`ifdef IF_PERF_CNT_EN
         check("stall_cnt",  bus.stall_cnt_o,  e.scnt);
         check("flush_cnt",  bus.flush_cnt_o,  e.fcnt);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total  = 0;
      bad    = 0;
      scnt_m = '0;
      fcnt_m = '0;
      rst_n  = 1'b0;
      bus.start_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.branch_target_i = '0;
      #2;
      check_reset("rst0");
      @(negedge clk);
      rst_n = 1'b1;

      //    st  stl fl  target         pc            ifid_pc       instr       v     h
      step(0, 0, 0, 32'h0,         32'h0,        32'h0,        32'd0,      0, 0);
      // sequential fetch
      step(1, 0, 0, 32'h0,         32'h4,        32'h0,        32'd100,    1, 0);
      step(1, 0, 0, 32'h0,         32'h8,        32'h4,        32'd101,    1, 0);
      // two-cycle stall at pc=8
      step(1, 1, 0, 32'h0,         32'h8,        32'h4,        32'd101,    1, 0);
      step(1, 1, 0, 32'h0,         32'h8,        32'h4,        32'd101,    1, 0);
      step(1, 0, 0, 32'h0,         32'hC,        32'h8,        32'd102,    1, 0);
      step(1, 0, 0, 32'h0,         32'h10,       32'hC,        32'd103,    1, 0);
      // taken branch to 0x40 from pc=0x10
      step(1, 0, 1, 32'h40,        32'h40,       32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h44,       32'h40,       32'd116,    1, 0);
      step(1, 0, 0, 32'h0,         32'h48,       32'h44,       32'd117,    1, 0);
      // redirect to 0x20, then stall+flush to 0x80 is ignored
      step(1, 0, 1, 32'h20,        32'h20,       32'h0,        32'd0,      0, 0);
      step(1, 1, 1, 32'h80,        32'h20,       32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h24,       32'h20,       32'd108,    1, 0);
      // run to the end of imem and halt
      step(1, 0, 1, 32'h3F8,       32'h3F8,      32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h3FC,      32'h3F8,      32'd354,    1, 0);
      step(1, 0, 0, 32'h0,         32'h400,      32'h3FC,      32'd355,    1, 0);
      step(1, 0, 0, 32'h0,         32'h400,      32'h0,        32'd0,      0, 1);
      step(1, 0, 0, 32'h0,         32'h400,      32'h0,        32'd0,      0, 1);
      step(1, 1, 0, 32'h0,         32'h400,      32'h0,        32'd0,      0, 1);
      // misaligned flush out of halt
      step(1, 0, 1, 32'h13,        32'h10,       32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h14,       32'h10,       32'd104,    1, 0);
      // fetch disabled for one cycle
      step(0, 0, 0, 32'h0,         32'h14,       32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h18,       32'h14,       32'd105,    1, 0);
      step(1, 0, 0, 32'h0,         32'h1C,       32'h18,       32'd106,    1, 0);
      step(1, 0, 0, 32'h0,         32'h20,       32'h1C,       32'd107,    1, 0);
      step(1, 1, 0, 32'h0,         32'h20,       32'h1C,       32'd107,    1, 0);
      step(1, 0, 0, 32'h0,         32'h24,       32'h20,       32'd108,    1, 0);

      // async reset between edges at pc=0x24
      #3;
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      scnt_m      = '0;
      fcnt_m      = '0;
      #1;
      check_reset("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 32'h0,         32'h0,        32'h0,        32'd0,      0, 0);
      step(0, 1, 1, 32'h40,        32'h0,        32'h0,        32'd0,      0, 0);
      step(1, 0, 0, 32'h0,         32'h4,        32'h0,        32'd100,    1, 0);

      repeat (3) @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_if_stage
